// File: rtl/sram_ctrl.sv
// Single-master front end for a 512 x 16 asynchronous SRAM: one word per request,
// strobes sequenced with WAIT_CYCLES of WE/OE low time, registered read data.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | chip in standby, bus released, ready for a request
// SETUP   | CE/address/byte lanes asserted, write data starts driving
// ACCESS  | WE or OE low for WAIT_CYCLES cycles
// RECOVER | WE/OE high, CE/address/data held; read response pulse
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [8:0]  req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [8:0]  sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic [8:0]  r_addr;
    logic        r_drive;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rdata;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_ub_n;
    logic        r_lb_n;
    logic [15:0] w_rd_masked;

    assign w_rd_masked = {r_be[1] ? sram_data[15:8] : 8'h00,
                          r_be[0] ? sram_data[7:0]  : 8'h00};

    // Write data stays on the bus through RECOVER to cover the SRAM data hold time.
    assign sram_data = r_drive ? r_wdata : 16'hzzzz;

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_ub_n;
    assign sram_lb_n = r_lb_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_be        <= 2'b00;
            r_wdata     <= 16'h0000;
            r_addr      <= 9'd0;
            r_drive     <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 16'h0000;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_state <= ST_SETUP;
                        r_ready <= 1'b0;
                        r_we    <= req_we;
                        r_be    <= req_be;
                        r_wdata <= req_wdata;
                        r_addr  <= req_addr;
                        r_drive <= req_we;
                        r_ce_n  <= 1'b0;
                        r_ub_n  <= ~req_be[1];
                        r_lb_n  <= ~req_be[0];
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    r_cnt   <= LP_CNT_INIT;
                    if (r_we) begin
                        r_we_n <= 1'b0;
                    end else begin
                        r_oe_n <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RECOVER;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        if (!r_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rd_masked;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_drive <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT_CYCLES 2 and 4) each with an SRAM model;
// a transaction-timeline model predicts every output on every cycle.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [8:0]  req_addr [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be [2];
    logic [15:0] rsp_rdata [2];
    logic [8:0]  sram_addr [2];
    logic [1:0]  ce_n, oe_n, we_n, ub_n, lb_n;
    wire  [15:0] sd0, sd1;

    logic [15:0] mem0 [512];
    logic [15:0] mem1 [512];
    logic [15:0] exp_mem [2][512];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state
    bit          busy [2];
    int          ph [2];
    logic        op_we [2];
    logic [8:0]  op_addr [2];
    logic [15:0] op_wdata [2];
    logic [1:0]  op_be [2];
    logic [15:0] exp_rdata [2];
    int          hs_cyc [2];
    int          hs_cnt [2];

    // observation counters
    int we_low [2], oe_low [2], rdy_low [2], rsp_n [2], rsp_cyc [2];

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .sram_addr(sram_addr[0]), .sram_data(sd0),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
        .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
    );

    sram_ctrl #(.WAIT_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .sram_addr(sram_addr[1]), .sram_data(sd1),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
        .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
    );

    // SRAM read drivers; in standby a keeper holds the bus at 0 so a stray controller drive shows up.
    assign sd0 = ce_n[0] ? 16'h0000 : (!oe_n[0] && we_n[0]) ? mem0[sram_addr[0]] : 16'hzzzz;
    assign sd1 = ce_n[1] ? 16'h0000 : (!oe_n[1] && we_n[1]) ? mem1[sram_addr[1]] : 16'hzzzz;

    function automatic int wcyc(input int d);
        return (d == 1) ? 4 : 2;
    endfunction

    function automatic logic [15:0] getbus(input int d);
        return (d == 1) ? sd1 : sd0;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // SRAM array writes
    always @(posedge clk) begin
        if (!ce_n[0] && !we_n[0]) begin
            if (!ub_n[0]) mem0[sram_addr[0]][15:8] = sd0[15:8];
            if (!lb_n[0]) mem0[sram_addr[0]][7:0]  = sd0[7:0];
        end
        if (!ce_n[1] && !we_n[1]) begin
            if (!ub_n[1]) mem1[sram_addr[1]][15:8] = sd1[15:8];
            if (!lb_n[1]) mem1[sram_addr[1]][7:0]  = sd1[7:0];
        end
    end

    // Transaction timeline: phase 1 = SETUP, 2..W+1 = ACCESS, W+2 = RECOVER, then idle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                busy[d] = 1'b0;
                exp_rdata[d] = 16'h0000;
            end else begin
                automatic bit was_busy = busy[d];
                automatic int w = wcyc(d);
                if (busy[d]) begin
                    ph[d]++;
                    if (ph[d] == w + 2 && !op_we[d])
                        exp_rdata[d] = {op_be[d][1] ? exp_mem[d][op_addr[d]][15:8] : 8'h00,
                                        op_be[d][0] ? exp_mem[d][op_addr[d]][7:0]  : 8'h00};
                    if (ph[d] == w + 3) begin
                        if (op_we[d] && op_be[d][1]) exp_mem[d][op_addr[d]][15:8] = op_wdata[d][15:8];
                        if (op_we[d] && op_be[d][0]) exp_mem[d][op_addr[d]][7:0]  = op_wdata[d][7:0];
                        busy[d] = 1'b0;
                    end
                end
                if (!was_busy && req_valid[d]) begin
                    busy[d]     = 1'b1;
                    ph[d]       = 1;
                    op_we[d]    = req_we[d];
                    op_addr[d]  = req_addr[d];
                    op_wdata[d] = req_wdata[d];
                    op_be[d]    = req_be[d];
                    hs_cyc[d]   = cyc;
                    hs_cnt[d]++;
                end
            end
        end
        cyc++;
    end

    // Per-cycle compare against the timeline model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int w = wcyc(d);
            automatic bit acc = busy[d] && ph[d] >= 2 && ph[d] <= w + 1;
            automatic bit chk_bus = 1'b1;
            automatic logic [15:0] e_bus = 16'h0000;
            if (!rst_n) begin
                check("rst_ready", d, req_ready[d], 1);
                check("rst_strobes", d, {ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]}, 5'b11111);
                check("rst_rsp_valid", d, rsp_valid[d], 0);
                check("rst_rdata", d, rsp_rdata[d], 0);
                check("rst_addr", d, sram_addr[d], 0);
                check("rst_bus", d, getbus(d), 0);
            end else begin
                check("req_ready", d, req_ready[d], !busy[d]);
                check("ce_n", d, ce_n[d], !busy[d]);
                check("we_n", d, we_n[d], !(acc && op_we[d]));
                check("oe_n", d, oe_n[d], !(acc && !op_we[d]));
                check("ub_n", d, ub_n[d], busy[d] ? !op_be[d][1] : 1'b1);
                check("lb_n", d, lb_n[d], busy[d] ? !op_be[d][0] : 1'b1);
                check("rsp_valid", d, rsp_valid[d], busy[d] && !op_we[d] && ph[d] == w + 2);
                check("rsp_rdata", d, rsp_rdata[d], exp_rdata[d]);
                if (busy[d]) check("sram_addr", d, sram_addr[d], op_addr[d]);
                if (busy[d] && op_we[d]) e_bus = op_wdata[d];
                else if (busy[d] && acc) e_bus = exp_mem[d][op_addr[d]];
                else if (busy[d]) chk_bus = 1'b0;
                if (chk_bus) check("sram_data", d, getbus(d), e_bus);
            end
            if (!we_n[d]) we_low[d]++;
            if (!oe_n[d]) oe_low[d]++;
            if (!req_ready[d]) rdy_low[d]++;
            if (rsp_valid[d]) begin
                rsp_n[d]++;
                rsp_cyc[d] = cyc;
            end
        end
    end

    task automatic wait_hs(input int d, input int n0);
        for (int k = 0; k < 20 && hs_cnt[d] == n0; k++) begin
            @(posedge clk);
            #1;
        end
        check("handshake_seen", d, hs_cnt[d] - n0, 1);
    endtask

    // One request: lat = rsp cycle minus handshake cycle (-1 if none), low = WE/OE low cycles.
    task automatic op(input int d, input bit we, input logic [8:0] a, input logic [15:0] wd,
                      input logic [1:0] be, output int lat, output int low);
        int n0, r0, w0, o0;
        n0 = hs_cnt[d]; r0 = rsp_n[d]; w0 = we_low[d]; o0 = oe_low[d];
        req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        req_valid[d] = 1'b1;
        wait_hs(d, n0);
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom); req_addr[d] = 9'($urandom);
        req_wdata[d] = 16'($urandom); req_be[d] = 2'($urandom);
        repeat (wcyc(d) + 2) @(posedge clk);
        #1;
        lat = (rsp_n[d] != r0) ? rsp_cyc[d] - hs_cyc[d] : -1;
        low = we ? we_low[d] - w0 : oe_low[d] - o0;
    endtask

    initial begin
        int lat, low, rel;
        int hs [3];
        int rl [3];
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 16'h0000; mem1[i] = 16'h0000;
            exp_mem[0][i] = 16'h0000; exp_mem[1][i] = 16'h0000;
        end
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; ph[d] = 0; hs_cnt[d] = 0; exp_rdata[d] = 0;
            we_low[d] = 0; oe_low[d] = 0; rdy_low[d] = 0; rsp_n[d] = 0; rsp_cyc[d] = 0;
        end
        rst_n = 1'b1;
        req_valid = 2'($urandom); req_we = 2'($urandom);
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = 9'($urandom); req_wdata[d] = 16'($urandom); req_be[d] = 2'($urandom);
        end
        #1 rst_n = 1'b0;

        // reset with random request inputs
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_strobes", d, {ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]}, 5'b11111);
            check("reset_ready", d, req_ready[d], 1);
            check("reset_rsp_valid", d, rsp_valid[d], 0);
            check("reset_addr", d, sram_addr[d], 9'h000);
            check("reset_bus", d, getbus(d), 16'h0000);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word write then read, W=2
        op(0, 1'b1, 9'h003, 16'hA55A, 2'b11, lat, low);
        check("t2_we_low_cycles", 0, low, 2);
        check("t2_write_no_rsp", 0, lat, -1);
        op(0, 1'b0, 9'h003, 16'h0000, 2'b11, lat, low);
        check("t2_oe_low_cycles", 0, low, 2);
        check("t2_read_latency", 0, lat, 4);
        check("t2_rdata", 0, rsp_rdata[0], 16'hA55A);

        // byte lanes
        op(0, 1'b1, 9'h010, 16'h1234, 2'b11, lat, low);
        op(0, 1'b1, 9'h010, 16'hABCD, 2'b10, lat, low);
        op(0, 1'b0, 9'h010, 16'h0000, 2'b11, lat, low);
        check("t3_read_be11", 0, rsp_rdata[0], 16'hAB34);
        op(0, 1'b0, 9'h010, 16'h0000, 2'b01, lat, low);
        check("t3_read_be01", 0, rsp_rdata[0], 16'h0034);
        op(0, 1'b0, 9'h010, 16'h0000, 2'b00, lat, low);
        check("t3_read_be00", 0, rsp_rdata[0], 16'h0000);
        check("t3_be00_rsp", 0, lat, 4);

        // back-to-back writes with req_valid held high
        req_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            automatic int n0 = hs_cnt[0];
            req_we[0] = 1'b1; req_addr[0] = 9'h040 + 9'(k);
            req_wdata[0] = 16'h1111 * 16'(k + 1); req_be[0] = 2'b11;
            wait_hs(0, n0);
            hs[k] = hs_cyc[0];
            rl[k] = rdy_low[0];
        end
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t4_hs_spacing_1", 0, hs[1] - hs[0], 5);
        check("t4_hs_spacing_2", 0, hs[2] - hs[1], 5);
        check("t4_ready_low_1", 0, rl[1] - rl[0], 4);
        check("t4_ready_low_2", 0, rl[2] - rl[1], 4);

        // reset during the second ACCESS cycle of a write
        begin
            automatic int n0 = hs_cnt[0];
            automatic int r0 = rsp_n[0];
            req_we[0] = 1'b1; req_addr[0] = 9'h020; req_wdata[0] = 16'hFFFF; req_be[0] = 2'b11;
            req_valid[0] = 1'b1;
            wait_hs(0, n0);
            req_valid[0] = 1'b0;
            @(posedge clk);
            #1;
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("t5_we_n", 0, we_n[0], 1);
            check("t5_ce_n", 0, ce_n[0], 1);
            check("t5_bus_released", 0, sd0, 16'h0000);
            check("t5_ready", 0, req_ready[0], 1);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            rel = cyc;
            op(0, 1'b0, 9'h003, 16'h0000, 2'b11, lat, low);
            check("t5_first_cycle_accept", 0, hs_cyc[0] - rel, 0);
            check("t5_single_rsp", 0, rsp_n[0] - r0, 1);
            check("t5_read_latency", 0, lat, 4);
            check("t5_rdata", 0, rsp_rdata[0], 16'hA55A);
        end

        // WAIT_CYCLES=4 and top address
        op(1, 1'b1, 9'h1FF, 16'h5A5A, 2'b11, lat, low);
        check("t6_we_low_cycles", 1, low, 4);
        check("t6_write_no_rsp", 1, lat, -1);
        op(1, 1'b0, 9'h1FF, 16'h0000, 2'b11, lat, low);
        check("t6_oe_low_cycles", 1, low, 4);
        check("t6_read_latency", 1, lat, 6);
        check("t6_rdata", 1, rsp_rdata[1], 16'h5A5A);
        op(1, 1'b0, 9'h000, 16'h0000, 2'b11, lat, low);
        check("t6_addr0_untouched", 1, rsp_rdata[1], 16'h0000);
        check("t6_addr0_latency", 1, lat, 6);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous front-end controller for the 512 x 16 asynchronous SRAM (active-low CE/OE/WE/UB/LB, 15 ns access). It accepts single-word read/write requests over a valid/ready handshake on the system clock. It sequences the SRAM control strobes with programmable wait states, drives and releases the shared bidirectional data bus, and returns registered read data with a one-cycle response pulse. It sits directly upstream of the SRAM and is its only master.

## Interface
Parameters:
- WAIT_CYCLES, 2, number of clock cycles the WE or OE strobe is held low; legal range 1..15. WAIT_CYCLES × clock period must be ≥ 15 ns.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  9  word address
- req_wdata  in  16  write data
- req_be  in  2  active-high byte enables; [1] = upper byte, [0] = lower byte
- rsp_valid  out  1  one-cycle pulse: read data valid
- rsp_rdata  out  16  read data; disabled bytes return 8'h00
- sram_addr  out  9  SRAM address
- sram_data  inout  16  SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RECOVER.
- IDLE:
  - req_ready = 1; all strobes high (chip in standby); sram_data released (Z).
  - A handshake (req_valid & req_ready at a rising edge) registers we, addr, wdata and be, then moves to SETUP.
- SETUP (1 cycle):
  - ce_n = 0; sram_addr = registered addr; ub_n = ~be[1], lb_n = ~be[0]; oe_n = we_n = 1.
  - For a write, the controller starts driving wdata onto sram_data.
- ACCESS (WAIT_CYCLES cycles, tracked by a 4-bit down-counter):
  - Write: we_n = 0.
  - Read: oe_n = 0; the bus is never driven by the controller.
  - On the edge that leaves ACCESS, a read captures sram_data into rsp_rdata, masking disabled bytes to 8'h00.
- RECOVER (1 cycle):
  - oe_n = we_n = 1; ce_n, addr, ub_n/lb_n and write data are all held (address/data hold after the WE rising edge).
  - rsp_valid = 1 for a read only. Next state is IDLE.
- req_be = 2'b00: the full sequence still runs with ub_n = lb_n = 1. A read returns 16'h0000 with rsp_valid.
- req_valid and the req_* fields are ignored outside IDLE; request fields are sampled only at the handshake.
- rsp_rdata holds its value until the next read capture.
- Reset, asynchronous and at any time including mid-operation:
  - state = IDLE; all five strobes = 1; sram_addr = 0; sram_data = Z.
  - rsp_valid = 0; rsp_rdata = 16'h0000; req_ready = 1.
  - An in-flight operation is dropped with no response. A write in progress may leave the target word corrupted.

## Timing
- Handshake in cycle n gives SETUP in n+1, ACCESS in n+2 .. n+1+W, RECOVER in n+2+W, and IDLE in n+3+W (W = WAIT_CYCLES).
- Read latency: rsp_valid is high in cycle n+2+W. Peak throughput is one operation per W+3 cycles.
- we_n/oe_n fall exactly one cycle after ce_n falls and addr/data are stable. They rise one cycle before ce_n rises and before the bus is released.
- sram_data is driven by the controller only in SETUP, ACCESS and RECOVER of a write.
- The bus is released in IDLE, so a read following a write always has at least 2 cycles of turnaround (IDLE + SETUP) before oe_n falls. No bus contention is possible.
- All outputs come from registers or decode of state only; there are no combinational paths from req_* to sram_*.

## Test plan
1. **Reset:** hold rst_n low with random req_* → all strobes 1, sram_data Z, req_ready 1, rsp_valid 0, sram_addr 0.
2. **Word write then read** (W = 2, 10 ns clock): write 16'hA55A to 9'h003 with be = 11, then read it → we_n low exactly 2 cycles; rsp_valid exactly 4 cycles after the read handshake; rsp_rdata = 16'hA55A.
3. **Byte lanes:** write 16'h1234 to 9'h010 with be = 11, then 16'hABCD with be = 10 → read with be = 11 returns 16'hAB34; read with be = 01 returns 16'h0034; read with be = 00 returns 16'h0000.
4. **Back-to-back requests:** hold req_valid high for 3 writes → handshakes exactly every 5 cycles; req_ready low for 4 cycles between them; no strobe glitch between operations.
5. **Reset mid-write:** pull rst_n low in the second ACCESS cycle → we_n and ce_n go high immediately, bus Z, no rsp_valid. After release, a new read is accepted in the first cycle.
6. **Parameter and address edge** (WAIT_CYCLES = 4): write 16'h5A5A to 9'h1FF and read it back → we_n and oe_n each low 4 cycles; rsp_valid 6 cycles after the handshake; rsp_rdata = 16'h5A5A; address 9'h000 is unaffected.
